seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul_pkg.sv | 18 +
 rtl/mul_acc_adder.sv | 43 ++++
 rtl/seq_mul.sv | 101 ++++++++++
 tb/tb_seq_mul.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding,
// default operand width and the bit-counter width helper.
package seq_mul_pkg;

  localparam int unsigned SEQ_MUL_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_mul_state_e;

  // One extra bit so the counter can represent WIDTH itself without aliasing.
  function automatic int unsigned seq_mul_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_acc_adder.sv
// WIDTH-bit adder built as a ripple of 4-bit carry-lookahead slices.
// WIDTH must be a multiple of 4.
module mul_acc_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned NSLICE = WIDTH / 4;

  logic [NSLICE:0] w_c;

  assign w_c[0] = Cin;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_k;

    assign w_g = X[4*gi +: 4] & Y[4*gi +: 4];
    assign w_p = X[4*gi +: 4] ^ Y[4*gi +: 4];

    // Every slice carry is formed directly from the slice carry-in.
    assign w_k[0] = w_c[gi];
    assign w_k[1] = w_g[0] | (w_p[0] & w_k[0]);
    assign w_k[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_k[0]);
    assign w_k[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_k[0]);
    assign w_k[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_k[0]);

    assign S[4*gi +: 4] = w_p ^ w_k[3:0];
    assign w_c[gi+1]    = w_k[4];
  end

  assign Cout = w_c[NSLICE];

endmodule

// File: rtl/seq_mul.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per RUN cycle.
// Optional feature macro SEQ_MUL_ZERO_SKIP_EN: zero operands bypass RUN.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CW = seq_mul_cnt_width(WIDTH);

  seq_mul_state_e     r_state;
  seq_mul_state_e     w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   w_mcand_nxt;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  assign w_addend = r_prod[0] ? r_mcand : '0;

  mul_acc_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .X    (r_prod[2*WIDTH-1:WIDTH]),
    .Y    (w_addend),
    .Cin  (1'b0),
    .S    (w_sum),
    .Cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_prod_nxt  = r_prod;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_mcand_nxt = a;
          w_prod_nxt  = {{WIDTH{1'b0}}, b};
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
`ifdef SEQ_MUL_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            w_prod_nxt  = '0;
            w_state_nxt = DONE;
          end
`endif
        end
      end
      RUN: begin
        // Carry-out becomes the new MSB so the full-scale product stays exact.
        w_prod_nxt = {w_cout, w_sum, r_prod[WIDTH-1:1]};
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcand <= w_mcand_nxt;
      r_prod  <= w_prod_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign p    = r_prod;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul (WIDTH=8): vector table, randomized
// operands against an arithmetic reference, and hand-written corner sequences.
module tb_seq_mul;

  localparam int W = 8;

`ifdef SEQ_MUL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] vp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seq_mul #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return longint'(x) * longint'(y);
  endfunction

  function automatic int exp_busy(input logic [W-1:0] x, input logic [W-1:0] y);
    return (SKIP && ((x == 0) || (y == 0))) ? 0 : W;
  endfunction

  // Counts busy cycles from the current negedge until done is seen (bounded).
  task automatic wait_done(output int bcnt, output bit seen);
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * W + 8; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input longint expp, input string name);
    int bc;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    wait_done(bc, seen);
    chk({name, " done seen"}, longint'(seen), 1);
    chk({name, " busy cycles"}, longint'(bc), longint'(exp_busy(ta, tb_v)));
    chk({name, " p"}, longint'(p), expp);
    @(negedge clk);
    chk({name, " done single pulse"}, longint'({busy, done}), 0);
    chk({name, " p hold"}, longint'(p), expp);
  endtask

  initial begin
    int  bc;
    bit  seen;
    int  ndone;
    int  nbusy;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{va: 8'd13,  vb: 8'd11,  vp: 16'h008F};
    vecs[1] = '{va: 8'd255, vb: 8'd255, vp: 16'hFE01};
    vecs[2] = '{va: 8'd0,   vb: 8'd77,  vp: 16'h0000};
    vecs[3] = '{va: 8'd1,   vb: 8'd1,   vp: 16'h0001};
    vecs[4] = '{va: 8'd128, vb: 8'd2,   vp: 16'h0100};
    vecs[5] = '{va: 8'd255, vb: 8'd1,   vp: 16'h00FF};
    vecs[6] = '{va: 8'd77,  vb: 8'd0,   vp: 16'h0000};
    vecs[7] = '{va: 8'd170, vb: 8'd85,  vp: 16'h3872};

    // Reset with start high and nonzero operands: start must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset p", longint'(p), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset idle", longint'({busy, done}), 0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, longint'(vecs[i].vp), $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (i == 3) ra = '0;
      if (i == 7) rb = '1;
      run_op(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
    end

    // Start re-pulsed during RUN must not disturb the operation.
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("ignore run cycle1 busy", longint'(busy), 1);
    @(negedge clk);
    start = 1'b1; a = 8'd7; b = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, seen);
    chk("ignore done seen", longint'(seen), 1);
    chk("ignore busy cycles", longint'(bc), longint'(W - 2));
    chk("ignore p", longint'(p), 15);
    @(negedge clk);

    // Reset at RUN cycle 4 aborts; start asserted during reset is ignored.
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort busy", longint'(busy), 0);
    chk("abort done", longint'(done), 0);
    chk("abort p", longint'(p), 0);
    rst_n = 1'b1;
    start = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      @(negedge clk);
    end
    chk("abort no done pulse", longint'(ndone), 0);
    chk("abort stays idle", longint'(nbusy), 0);

    // Back-to-back with start held high: DONE accepts the next operation.
    start = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge clk);
    a = 8'd6; b = 8'd7;
    wait_done(bc, seen);
    chk("b2b first done seen", longint'(seen), 1);
    chk("b2b first busy cycles", longint'(bc), W);
    chk("b2b first p", longint'(p), 81);
    @(negedge clk);
    chk("b2b no idle gap", longint'({busy, done}), 2);
    start = 1'b0;
    wait_done(bc, seen);
    chk("b2b second done seen", longint'(seen), 1);
    chk("b2b second busy cycles", longint'(bc), W);
    chk("b2b second p", longint'(p), 42);
    @(negedge clk);
    chk("b2b end idle", longint'({busy, done}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
